// File: rtl/control_barrera_pkg.sv
// Shared definitions for the car-park barrier controller: FSM state encoding
// and direction constants used for grants and the sentido output.
package control_barrera_pkg;

  typedef enum logic [1:0] {
    REPOSO      = 2'd0,
    ABIERTA_IN  = 2'd1,
    ABIERTA_OUT = 2'd2,
    GUARDA      = 2'd3
  } estado_t;

  localparam logic DIR_IN  = 1'b1;
  localparam logic DIR_OUT = 1'b0;

endpackage

// File: rtl/control_barrera_temporizador.sv
// Up-counter with synchronous clear that stops at a terminal value, so a
// missed exit condition can never make it wrap around.
module temporizador_barrera #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] limite,
  output logic         fin
);

  logic [W-1:0] cuenta;

  assign fin = (cuenta == limite);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cuenta <= '0;
    else if (clr)   cuenta <= '0;
    else if (!fin)  cuenta <= cuenta + 1'b1;
  end

endmodule

// File: rtl/control_barrera.sv
// Single-barrier arbiter for the one-lane car park: grants entry or exit,
// holds the barrier open until the car passes or the window times out.
module control_barrera
  import control_barrera_pkg::*;
#(
  parameter int CAPACIDAD = 7,
  parameter int T_ABIERTA = 8,
  parameter int T_GUARDA  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_entrada,
  input  logic       req_salida,
  input  logic       paso_in,
  input  logic       paso_out,
  input  logic [2:0] cantidad,
  output logic       barrera,
  output logic       sentido,
  output logic       lleno,
  output logic       ocupado,
  output logic       error_tiempo
);

  localparam int T_MAX = (T_ABIERTA > T_GUARDA) ? T_ABIERTA : T_GUARDA;
  localparam int TW    = $clog2(T_MAX + 1);

  estado_t       estado, estado_sig;
  logic          ultimo, ultimo_sig;
  logic          err_sig;
  logic          ent_ok, sal_ok;
  logic          clr, fin;
  logic [TW-1:0] limite;

  assign lleno  = (int'(cantidad) >= CAPACIDAD);
  assign ent_ok = req_entrada && !lleno;
  assign sal_ok = req_salida && (cantidad != 3'd0);

  // Idle holds the timer at zero; any state change restarts it.
  assign clr = (estado_sig != estado) || (estado == REPOSO);

  temporizador_barrera #(.W(TW)) u_temporizador (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .limite (limite),
    .fin    (fin)
  );

  always_comb begin
    estado_sig = estado;
    ultimo_sig = ultimo;
    err_sig    = 1'b0;
    limite     = '0;
    case (estado)
      REPOSO: begin
        // On contention the direction not served last wins.
        if (ent_ok && (!sal_ok || ultimo == DIR_OUT)) begin
          estado_sig = ABIERTA_IN;
          ultimo_sig = DIR_IN;
        end else if (sal_ok) begin
          estado_sig = ABIERTA_OUT;
          ultimo_sig = DIR_OUT;
        end
      end
      ABIERTA_IN: begin
        limite = TW'(T_ABIERTA - 1);
        if (paso_in) begin
          estado_sig = GUARDA;
        end else if (fin) begin
          estado_sig = GUARDA;
          err_sig    = 1'b1;
        end
      end
      ABIERTA_OUT: begin
        limite = TW'(T_ABIERTA - 1);
        if (paso_out) begin
          estado_sig = GUARDA;
        end else if (fin) begin
          estado_sig = GUARDA;
          err_sig    = 1'b1;
        end
      end
      GUARDA: begin
        limite = TW'(T_GUARDA - 1);
        if (fin) estado_sig = REPOSO;
      end
      default: estado_sig = REPOSO;
    endcase
  end

  // Outputs are registered from the next state, giving one cycle of latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado       <= REPOSO;
      ultimo       <= DIR_OUT;
      barrera      <= 1'b0;
      sentido      <= DIR_IN;
      ocupado      <= 1'b0;
      error_tiempo <= 1'b0;
    end else begin
      estado       <= estado_sig;
      ultimo       <= ultimo_sig;
      barrera      <= (estado_sig == ABIERTA_IN) || (estado_sig == ABIERTA_OUT);
      ocupado      <= (estado_sig != REPOSO);
      error_tiempo <= err_sig;
      if (estado == REPOSO && estado_sig != REPOSO) sentido <= ultimo_sig;
    end
  end

endmodule
